// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the scoreboarded register file
package regfile_pkg;

   localparam int DW_DEF   = 32;
   localparam int AW_DEF   = 5;
   localparam int NR_DEF   = 2;
   localparam int REG_ZERO = 0;

   typedef logic [2**AW_DEF-1:0] pend_t;
   typedef logic [AW_DEF:0]      pcnt_t;

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/write/mark bus between the pipeline and the register file
interface regfile_sb_if #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int NR = 2
);
   logic [NR*AW-1:0] Ra;
   logic [NR*DW-1:0] Qa;
   logic [NR-1:0]    Busy;
   logic             We;
   logic [AW-1:0]    Wn;
   logic [DW-1:0]    D;
   logic             Mk;
   logic [AW-1:0]    Mn;
   logic             Flush;
   logic [AW:0]      Pcnt;

   modport master (output Ra, We, Wn, D, Mk, Mn, Flush, input Qa, Busy, Pcnt);
   modport slave  (input Ra, We, Wn, D, Mk, Mn, Flush, output Qa, Busy, Pcnt);
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-producer bits and their popcount counter
// Priority: flush, then mark, then writeback clear.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mk,
   input  logic [AW-1:0]     mn,
   input  logic              we,
   input  logic [AW-1:0]     wn,
   input  logic              flush,
   output logic [2**AW-1:0]  pend,
   output logic [AW:0]       pcnt
);
   localparam int CW = AW + 1;

   logic              set_ok;
   logic              clr_ok;
   logic [2**AW-1:0]  pend_nxt;
   logic [AW:0]       pcnt_nxt;

   // A same-register mark means a newer producer, so it suppresses the clear.
   assign set_ok = mk && (mn != AW'(REG_ZERO));
   assign clr_ok = we && (wn != AW'(REG_ZERO)) && !(set_ok && (mn == wn));

   always_comb begin
      pend_nxt = pend;
      pcnt_nxt = pcnt;
      if (flush) begin
         pend_nxt = '0;
         pcnt_nxt = '0;
      end else begin
         if (clr_ok) pend_nxt[wn] = 1'b0;
         if (set_ok) pend_nxt[mn] = 1'b1;
         pcnt_nxt = pcnt + CW'(set_ok && !pend[mn]) - CW'(clr_ok && pend[wn]);
      end
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
         pcnt <= '0;
      end else begin
         pend <= pend_nxt;
         pcnt <= pcnt_nxt;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with pending scoreboard
// REGFILE_BYPASS_EN: same-cycle write-through to matching read ports, which also clears their Busy.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF,
   parameter int NR = NR_DEF
) (
   input logic         Clk,
   input logic         Clrn,
   regfile_sb_if.slave bus
);
   logic [DW-1:0]     mem [2**AW];
   logic [2**AW-1:0]  pend;
   logic              wr_en;
   logic [NR*DW-1:0]  qa;
   logic [NR-1:0]     busy;

   assign wr_en = bus.We && (bus.Wn != AW'(REG_ZERO));

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[bus.Wn] <= bus.D;
      end
   end

   always_comb begin
      qa   = '0;
      busy = '0;
      for (int k = 0; k < NR; k++) begin
         if (bus.Ra[k*AW +: AW] != AW'(REG_ZERO)) begin
            qa[k*DW +: DW] = mem[bus.Ra[k*AW +: AW]];
            busy[k]        = pend[bus.Ra[k*AW +: AW]];
         end
`ifdef REGFILE_BYPASS_EN
         if (wr_en && (bus.Wn == bus.Ra[k*AW +: AW])) begin
            qa[k*DW +: DW] = bus.D;
            busy[k]        = 1'b0;
         end
`endif
      end
   end

   assign bus.Qa   = qa;
   assign bus.Busy = busy;

   regfile_scoreboard #(.AW(AW)) u_sb (
      .clk   (Clk),
      .rst_n (Clrn),
      .mk    (bus.Mk),
      .mn    (bus.Mn),
      .we    (bus.We),
      .wn    (bus.Wn),
      .flush (bus.Flush),
      .pend  (pend),
      .pcnt  (bus.Pcnt)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb (default and NR=3/AW=4/DW=16 instances)
// Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;
   import regfile_pkg::*;

   logic Clk;
   logic Clrn;

   regfile_sb_if #(.DW(32), .AW(5), .NR(2)) bus ();
   regfile_sb_if #(.DW(16), .AW(4), .NR(3)) bus3 ();

   regfile_sb #(.DW(32), .AW(5), .NR(2)) u_dut (
      .Clk  (Clk),
      .Clrn (Clrn),
      .bus  (bus.slave)
   );

   regfile_sb #(.DW(16), .AW(4), .NR(3)) u_dut3 (
      .Clk  (Clk),
      .Clrn (Clrn),
      .bus  (bus3.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int          checks;
   int          passed;
   logic [31:0] exp_q [$];
   logic [31:0] e;
   logic [31:0] got;
   pend_t       m_pend;
   logic [15:0] mem3 [16];

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      bus.Ra = '0;  bus.We = 1'b0;  bus.Wn = '0;  bus.D = '0;
      bus.Mk = 1'b0; bus.Mn = '0;   bus.Flush = 1'b0;
      bus3.Ra = '0; bus3.We = 1'b0; bus3.Wn = '0; bus3.D = '0;
      bus3.Mk = 1'b0; bus3.Mn = '0; bus3.Flush = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      Clrn = 1'b1;
      #1 Clrn = 1'b0;
      bus.Ra = {5'd0, 5'd3};
      tick();
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      for (int p = 0; p < 2; p++) begin
         got = bus.Qa[p*32 +: 32]; e = exp_q.pop_front(); checks++;
         if (got !== e) $display("FAIL reset_qa%0d got=%h exp=%h", p, got, e); else passed++;
      end
      got = 32'(bus.Busy); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL reset_busy got=%h exp=%h", got, e); else passed++;
      got = 32'(bus.Pcnt); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL reset_pcnt got=%0d exp=%0d", got, e); else passed++;
      Clrn = 1'b1;
      tick();
      // reset asserted while a write is presented across an edge
      bus.We = 1'b1; bus.Wn = 5'd3; bus.D = 32'hDEADBEEF;
      #1 Clrn = 1'b0;
      tick();
      Clrn = 1'b1; bus.We = 1'b0;
      tick();
      exp_q.push_back(32'h0);
      #2;
      got = bus.Qa[31:0]; e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL reset_midwrite got=%h exp=%h", got, e); else passed++;
   endtask

   task automatic test_write_read();
      idle();
      bus.We = 1'b1; bus.Wn = 5'd5; bus.D = 32'h1234_5678; bus.Ra = {5'd0, 5'd5};
      exp_q.push_back(BYP ? 32'h1234_5678 : 32'h0);
      #2;
      got = bus.Qa[31:0]; e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL wr_same_cycle got=%h exp=%h", got, e); else passed++;
      tick();
      bus.We = 1'b0;
      exp_q.push_back(32'h1234_5678);
      #2;
      got = bus.Qa[31:0]; e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL wr_next_cycle got=%h exp=%h", got, e); else passed++;
      bus.We = 1'b1; bus.Wn = 5'd0; bus.D = 32'hFFFF_FFFF; bus.Ra = {5'd5, 5'd0};
      exp_q.push_back(32'h0);
      #2;
      got = bus.Qa[31:0]; e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL wr_zero_bypass got=%h exp=%h", got, e); else passed++;
      tick();
      bus.We = 1'b0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h1234_5678);
      #2;
      got = bus.Qa[31:0]; e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL wr_zero_read got=%h exp=%h", got, e); else passed++;
      got = bus.Qa[63:32]; e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL wr_port1_r5 got=%h exp=%h", got, e); else passed++;
   endtask

   task automatic test_scoreboard();
      idle();
      bus.Mk = 1'b1; bus.Mn = 5'd7; bus.Ra = {5'd0, 5'd7};
      exp_q.push_back(32'h0);
      #2;
      got = 32'(bus.Busy[0]); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL sb_busy_before got=%0d exp=%0d", got, e); else passed++;
      tick();
      bus.Mk = 1'b0;
      exp_q.push_back(32'h1); exp_q.push_back(32'h1);
      #2;
      got = 32'(bus.Busy[0]); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL sb_busy_marked got=%0d exp=%0d", got, e); else passed++;
      got = 32'(bus.Pcnt); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL sb_pcnt_marked got=%0d exp=%0d", got, e); else passed++;
      bus.We = 1'b1; bus.Wn = 5'd7; bus.D = 32'h0000_AAAA;
      exp_q.push_back(BYP ? 32'h0 : 32'h1);
      #2;
      got = 32'(bus.Busy[0]); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL sb_busy_wb_cycle got=%0d exp=%0d", got, e); else passed++;
      tick();
      bus.We = 1'b0;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #2;
      got = 32'(bus.Busy[0]); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL sb_busy_cleared got=%0d exp=%0d", got, e); else passed++;
      got = 32'(bus.Pcnt); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL sb_pcnt_cleared got=%0d exp=%0d", got, e); else passed++;
   endtask

   task automatic test_same_cycle();
      idle();
      bus.Mk = 1'b1; bus.Mn = 5'd9;
      tick();
      bus.We = 1'b1; bus.Wn = 5'd9; bus.D = 32'h9;
      tick();
      idle();
      bus.Ra = {5'd0, 5'd9};
      exp_q.push_back(32'h1); exp_q.push_back(32'h1);
      #2;
      got = 32'(bus.Busy[0]); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL same_reg_busy got=%0d exp=%0d", got, e); else passed++;
      got = 32'(bus.Pcnt); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL same_reg_pcnt got=%0d exp=%0d", got, e); else passed++;
      bus.Mk = 1'b1; bus.Mn = 5'd4; bus.We = 1'b1; bus.Wn = 5'd9; bus.D = 32'h99;
      tick();
      idle();
      bus.Ra = {5'd9, 5'd4};
      exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
      #2;
      got = 32'(bus.Busy[0]); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL diff_reg_busy4 got=%0d exp=%0d", got, e); else passed++;
      got = 32'(bus.Busy[1]); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL diff_reg_busy9 got=%0d exp=%0d", got, e); else passed++;
      got = 32'(bus.Pcnt); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL diff_reg_pcnt got=%0d exp=%0d", got, e); else passed++;
   endtask

   task automatic test_flush();
      // register 4 is still pending from the previous scenario; re-marking must not count
      idle();
      bus.Mk = 1'b1;
      bus.Mn = 5'd2; tick();
      bus.Mn = 5'd3; tick();
      bus.Mn = 5'd4; tick();
      idle();
      exp_q.push_back(32'd3);
      #2;
      got = 32'(bus.Pcnt); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL flush_pre_pcnt got=%0d exp=%0d", got, e); else passed++;
      bus.Flush = 1'b1; bus.Mk = 1'b1; bus.Mn = 5'd6;
      tick();
      idle();
      bus.Ra = {5'd2, 5'd6};
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #2;
      got = 32'(bus.Pcnt); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL flush_pcnt got=%0d exp=%0d", got, e); else passed++;
      got = 32'(bus.Busy); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL flush_busy got=%h exp=%h", got, e); else passed++;
      bus.Ra = {5'd4, 5'd3};
      exp_q.push_back(32'h0);
      #2;
      got = 32'(bus.Busy); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL flush_busy34 got=%h exp=%h", got, e); else passed++;
   endtask

   task automatic test_sweep();
      logic [3:0] a;
      idle();
      mem3[0] = '0;
      for (int i = 1; i < 16; i++) begin
         bus3.We = 1'b1; bus3.Wn = 4'(i); bus3.D = 16'($urandom);
         mem3[i] = bus3.D;
         tick();
      end
      bus3.Wn = 4'd0; bus3.D = 16'hFFFF;
      tick();
      bus3.We = 1'b0;
      for (int r = 0; r < 20; r++) begin
         bus3.Ra = 12'($urandom);
         for (int p = 0; p < 3; p++) begin
            a = bus3.Ra[p*4 +: 4];
            exp_q.push_back(32'((a == 4'd0) ? 16'h0 : mem3[a]));
         end
         #2;
         for (int p = 0; p < 3; p++) begin
            got = 32'(bus3.Qa[p*16 +: 16]); e = exp_q.pop_front(); checks++;
            if (got !== e) $display("FAIL sweep_r%0d_p%0d got=%h exp=%h", r, p, got, e); else passed++;
         end
         tick();
      end
   endtask

   task automatic test_random_pcnt();
      pend_t nxt;
      idle();
      m_pend = '0;
      for (int c = 0; c < 10000; c++) begin
         bus.Flush = ($urandom_range(49) == 0);
         bus.Mk    = $urandom_range(1);
         bus.Mn    = 5'($urandom);
         bus.We    = $urandom_range(1);
         bus.Wn    = 5'($urandom);
         bus.D     = $urandom;
         bus.Ra    = 10'($urandom);
         nxt = m_pend;
         if (bus.Flush) nxt = '0;
         else begin
            if (bus.We && bus.Wn != 5'd0) nxt[bus.Wn] = 1'b0;
            if (bus.Mk && bus.Mn != 5'd0) nxt[bus.Mn] = 1'b1;
         end
         m_pend = nxt;
         exp_q.push_back(32'($countones(m_pend)));
         tick();
         got = 32'(bus.Pcnt); e = exp_q.pop_front(); checks++;
         if (got !== e) $display("FAIL rand_pcnt cyc=%0d got=%0d exp=%0d", c, got, e); else passed++;
      end
      idle();
      bus.Ra = {5'd17, 5'd1};
      exp_q.push_back(32'({m_pend[17], m_pend[1]}));
      #2;
      got = 32'(bus.Busy); e = exp_q.pop_front(); checks++;
      if (got !== e) $display("FAIL rand_final_busy got=%h exp=%h", got, e); else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_write_read();
      test_scoreboard();
      test_same_cycle();
      test_flush();
      test_sweep();
      test_random_pcnt();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port register file for the pipelined CPU, succeeding the fixed 2-read/1-write, 32x32 register file.
- Adds a write-to-read bypass.
- Adds a per-register pending scoreboard: long-latency producers (loads, multicycle ops) mark their destination at issue, and writeback clears the mark. This drives load-use stall detection in ID.
- Register 0 is hardwired to zero.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth is 2**AW with entry 0 hardwired zero.
- NR, 2, number of read ports (1..4).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Clrn  in  1  asynchronous reset, active-low.
- Ra  in  NR*AW  read addresses; port k uses Ra[k*AW +: AW].
- Qa  out  NR*DW  read data; port k uses Qa[k*DW +: DW]. Combinational.
- Busy  out  NR  Busy[k] is high when Ra[k] has an outstanding pending producer.
- We  in  1  write enable.
- Wn  in  AW  write address.
- D  in  DW  write data.
- Mk  in  1  mark-pending strobe (producer issued).
- Mn  in  AW  register to mark pending.
- Flush  in  1  clears all pending marks (pipeline flush).
- Pcnt  out  AW+1  registered count of pending registers.

Behaviour:
- Reset (Clrn=0, asynchronous):
  - All registers 1..2**AW-1 are 0.
  - All pending bits are 0; Pcnt=0.
  - Hence Qa=0 and Busy=0 for every port.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-operation discards any write or mark presented in the same cycle.
- Write: at the rising edge, if We=1 and Wn!=0, then reg[Wn]<=D. A write to Wn=0 is ignored entirely: no data change, no pending clear.
- Read port k: if Ra[k]==0, Qa_k=0. Otherwise Qa_k=reg[Ra[k]], subject to the bypass (see Optional Feature).
- Pending bits: one bit per register 1..2**AW-1; bit 0 is constant 0. Next-state priority, highest first:
  1. Flush=1: all bits cleared. Mk and the write-clear are ignored in that cycle. The data write still happens.
  2. Mk=1 and Mn!=0: pend[Mn] is set. This wins over a same-cycle clear of the same register, because a newer producer has been issued.
  3. We=1 and Wn!=0: pend[Wn] is cleared.
  - Mk and We on different registers in the same cycle are both applied.
- Busy[k] = pend[Ra[k]], qualified by the bypass rule in Optional Feature. Busy is 0 when Ra[k]==0.
- Pcnt:
  - Registered up/down counter; must always equal the popcount of the pending bits.
  - Next value: +1 for a set of a previously clear bit; -1 for a clear of a previously set bit.
  - Set and clear on different registers in the same cycle gives net 0.
  - Marking an already-pending register does not count.
  - Flush gives 0.
  - Range 0..2**AW-1; it cannot overflow by construction.
- Latency:
  - Reads are 0-cycle combinational.
  - Writes and marks are visible in the registered state one edge later.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If We=1, Wn!=0 and Wn==Ra[k], then Qa_k=D (write-through in the same cycle).
  - Busy[k] is forced to 0 for that port in that cycle, because the write resolves the hazard.
- Undefined:
  - Qa_k returns the pre-edge register contents.
  - Busy[k] reflects the registered pend only.
  - ID must then stall one extra cycle on a writeback collision.
- The pending-bit update rules are identical in both builds.

Decomposition:
- Shared package regfile_pkg:
  - default DW/AW/NR constants;
  - REG_ZERO address constant;
  - typedef for the pending vector (logic [2**AW-1:0]);
  - typedef for the Pcnt width.
- One natural sub-module, regfile_scoreboard: holds the pending bits, the Pcnt counter and the set/clear/flush priority logic. The data array, read muxes and bypass stay in regfile_sb.

Test Plan:
- Reset check: Clrn=0 with Ra={3,0} -> Qa={0,0}, Busy=0, Pcnt=0. Pulse Clrn low mid-write of D=32'hDEADBEEF to Wn=3 -> reg[3] stays 0.
- Write then read: We=1, Wn=5, D=32'h1234_5678, Ra[0]=5 in the same cycle -> Qa_0=32'h12345678 with REGFILE_BYPASS_EN, old value 0 without it. Next cycle -> 32'h12345678 in both builds. Write to Wn=0 with D=32'hFFFFFFFF -> read of 0 returns 0.
- Scoreboard: Mk=1, Mn=7 -> next cycle Busy for Ra=7 is 1 and Pcnt=1. Later We=1, Wn=7 -> Busy=0 that cycle (bypass build), pend cleared and Pcnt=0 next cycle.
- Same-cycle set and clear of one register: Mk=1, Mn=9 with We=1, Wn=9 while pend[9]=1 -> pend[9] stays 1, Pcnt unchanged. Mk on register 4 with We on register 9 -> pend[4]=1, pend[9]=0, Pcnt unchanged.
- Flush: mark registers 2, 3, 4 (Pcnt=3), then Flush=1 together with Mk=1, Mn=6 -> all pend 0, Pcnt=0, Busy=0.
- Parameter sweep: NR=3, AW=4, DW=16 -> three independent read ports return correct data. Random set/clear/flush for 10k cycles -> Pcnt equals the popcount of the pending bits every cycle.
